// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - EXE-to-WB memory stage with a valid/ready data-memory handshake
module mem_stage_hs #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic              ex_rdsrc,
  input  logic [XLEN-1:0]   ex_aluout,
  input  logic [XLEN-1:0]   ex_pctoreg,
  input  logic [XLEN-1:0]   ex_rs2data,
  input  logic [4:0]        ex_rdaddr,
  input  logic [2:0]        ex_funct3,
  output logic [XLEN-1:0]   fwd_rddata,
  output logic              stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_rddata,
  output logic [XLEN-1:0]   wb_dout,
  output logic [4:0]        wb_rdaddr,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic              exc_misalign,
  output logic              exc_buserr,
  output logic              dm_req,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [XLEN/8-1:0] dm_wstrb,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic              dm_err,
  input  logic [XLEN-1:0]   dm_rdata
);
  localparam int SW = XLEN / 8;
  localparam int OW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]     lane_q, lane_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              load_q, load_d;
  logic [XLEN-1:0]   rddata_q, rddata_d;
  logic [4:0]        rdaddr_q, rdaddr_d;
  logic              memtoreg_q, memtoreg_d, regwrite_q, regwrite_d;
  logic              wb_valid_q, wb_valid_d, wb_memtoreg_q, wb_memtoreg_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [XLEN-1:0]   wb_rddata_q, wb_rddata_d, wb_dout_q, wb_dout_d;
  logic [4:0]        wb_rdaddr_q, wb_rdaddr_d;
  logic              exc_misalign_q, exc_misalign_d, exc_buserr_q, exc_buserr_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [XLEN-1:0]   dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [SW-1:0]     dm_wstrb_q, dm_wstrb_d;

  logic [OW-1:0]     lane, amask;
  logic [SW-1:0]     strb_base, strb;
  logic [XLEN-1:0]   wshift, wdata, rshift, ldata;
  logic              illegal, misalign, timed_out;

  assign fwd_rddata = ex_rdsrc ? ex_pctoreg : ex_aluout;
  assign ex_ready   = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign lane       = ex_aluout[OW-1:0];
  assign timed_out  = (cnt_q >= CNT_W'(TIMEOUT - 1));

  // Access decode: legality, alignment, store lanes and data placement
  always_comb begin
    illegal = (XLEN == 32) ? (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11)
                           : (ex_funct3 == 3'b111);
    case (ex_funct3[1:0])
      2'd0:    begin amask = '0;       strb_base = SW'(1);  end
      2'd1:    begin amask = OW'(1);   strb_base = SW'(3);  end
      2'd2:    begin amask = OW'(3);   strb_base = SW'(15); end
      default: begin amask = OW'(7);   strb_base = '1;      end
    endcase
    misalign = |(lane & amask);
    strb     = strb_base << lane;
    wshift   = ex_rs2data << {lane, 3'b000};
    wdata    = '0;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) wdata[8*i +: 8] = wshift[8*i +: 8];
    end
  end

  always_comb begin
    rshift = dm_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  ldata = XLEN'($signed(rshift[7:0]));
      3'b001:  ldata = XLEN'($signed(rshift[15:0]));
      3'b010:  ldata = XLEN'($signed(rshift[31:0]));
      3'b100:  ldata = XLEN'(rshift[7:0]);
      3'b101:  ldata = XLEN'(rshift[15:0]);
      3'b110:  ldata = XLEN'(rshift[31:0]);
      default: ldata = rshift;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lane_d         = lane_q;
    funct3_d       = funct3_q;
    load_d         = load_q;
    rddata_d       = rddata_q;
    rdaddr_d       = rdaddr_q;
    memtoreg_d     = memtoreg_q;
    regwrite_d     = regwrite_q;
    wb_valid_d     = 1'b0;
    wb_rddata_d    = wb_rddata_q;
    wb_dout_d      = wb_dout_q;
    wb_rdaddr_d    = wb_rdaddr_q;
    wb_memtoreg_d  = wb_memtoreg_q;
    wb_regwrite_d  = wb_regwrite_q;
    exc_misalign_d = 1'b0;
    exc_buserr_d   = 1'b0;
    dm_req_d       = dm_req_q;
    dm_we_d        = dm_we_q;
    dm_addr_d      = dm_addr_q;
    dm_wstrb_d     = dm_wstrb_q;
    dm_wdata_d     = dm_wdata_q;
    case (state_q)
      IDLE: if (ex_valid) begin
        cnt_d = '0;
        if (!(ex_memread || ex_memwrite) || illegal || misalign) begin
          wb_valid_d     = 1'b1;
          wb_rddata_d    = fwd_rddata;
          wb_rdaddr_d    = ex_rdaddr;
          wb_memtoreg_d  = ex_memtoreg;
          wb_regwrite_d  = ex_regwrite;
          if (ex_memread || ex_memwrite) begin
            wb_regwrite_d  = 1'b0;
            exc_buserr_d   = illegal;
            exc_misalign_d = !illegal;
          end
        end else begin
          state_d    = REQ;
          lane_d     = lane;
          funct3_d   = ex_funct3;
          load_d     = ex_memread && !ex_memwrite;
          rddata_d   = fwd_rddata;
          rdaddr_d   = ex_rdaddr;
          memtoreg_d = ex_memtoreg;
          regwrite_d = ex_regwrite;
          dm_req_d   = 1'b1;
          dm_we_d    = ex_memwrite;
          dm_addr_d  = {ex_aluout[XLEN-1:OW], OW'(0)};
          dm_wstrb_d = ex_memwrite ? strb : '0;
          dm_wdata_d = ex_memwrite ? wdata : '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!timed_out && dm_gnt) begin
          state_d  = RSP;
          dm_req_d = 1'b0;
        end
      end
      default: cnt_d = cnt_q + CNT_W'(1);
    endcase
    // A response arriving on the timeout edge still completes normally
    if ((state_q == RSP && dm_rvalid) || (state_q != IDLE && timed_out)) begin
      state_d       = IDLE;
      dm_req_d      = 1'b0;
      wb_valid_d    = 1'b1;
      wb_rddata_d   = rddata_q;
      wb_rdaddr_d   = rdaddr_q;
      wb_memtoreg_d = memtoreg_q;
      if (state_q == RSP && dm_rvalid) begin
        wb_regwrite_d = regwrite_q && !dm_err;
        exc_buserr_d  = dm_err;
        if (load_q && !dm_err) wb_dout_d = ldata;
      end else begin
        wb_regwrite_d = 1'b0;
        exc_buserr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;          cnt_q <= '0;          lane_q <= '0;
      funct3_q <= '0;           load_q <= 1'b0;       rddata_q <= '0;
      rdaddr_q <= '0;           memtoreg_q <= 1'b0;   regwrite_q <= 1'b0;
      wb_valid_q <= 1'b0;       wb_rddata_q <= '0;    wb_dout_q <= '0;
      wb_rdaddr_q <= '0;        wb_memtoreg_q <= 1'b0; wb_regwrite_q <= 1'b0;
      exc_misalign_q <= 1'b0;   exc_buserr_q <= 1'b0;
      dm_req_q <= 1'b0;         dm_we_q <= 1'b0;      dm_addr_q <= '0;
      dm_wstrb_q <= '0;         dm_wdata_q <= '0;
    end else begin
      state_q <= state_d;       cnt_q <= cnt_d;       lane_q <= lane_d;
      funct3_q <= funct3_d;     load_q <= load_d;     rddata_q <= rddata_d;
      rdaddr_q <= rdaddr_d;     memtoreg_q <= memtoreg_d; regwrite_q <= regwrite_d;
      wb_valid_q <= wb_valid_d; wb_rddata_q <= wb_rddata_d; wb_dout_q <= wb_dout_d;
      wb_rdaddr_q <= wb_rdaddr_d; wb_memtoreg_q <= wb_memtoreg_d; wb_regwrite_q <= wb_regwrite_d;
      exc_misalign_q <= exc_misalign_d; exc_buserr_q <= exc_buserr_d;
      dm_req_q <= dm_req_d;     dm_we_q <= dm_we_d;   dm_addr_q <= dm_addr_d;
      dm_wstrb_q <= dm_wstrb_d; dm_wdata_q <= dm_wdata_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rddata    = wb_rddata_q;
  assign wb_dout      = wb_dout_q;
  assign wb_rdaddr    = wb_rdaddr_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign exc_misalign = exc_misalign_q;
  assign exc_buserr   = exc_buserr_q;
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wstrb     = dm_wstrb_q;
  assign dm_wdata     = dm_wdata_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed bench for mem_stage_hs at XLEN 32 and 64
module tb_mem_stage_hs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32-bit instance, short timeout
  logic        a_ex_valid, a_memread, a_memwrite, a_memtoreg, a_regwrite, a_rdsrc;
  logic [31:0] a_aluout, a_pctoreg, a_rs2data, a_fwd, a_wb_rddata, a_wb_dout, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [4:0]  a_rdaddr, a_wb_rdaddr;
  logic [2:0]  a_funct3;
  logic [3:0]  a_dm_wstrb;
  logic        a_ex_ready, a_stall, a_wb_valid, a_wb_memtoreg, a_wb_regwrite, a_exc_mis, a_exc_bus;
  logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid, a_dm_err;

  // 64-bit instance, default timeout
  logic        b_ex_valid, b_memread, b_memwrite, b_memtoreg, b_regwrite, b_rdsrc;
  logic [63:0] b_aluout, b_pctoreg, b_rs2data, b_fwd, b_wb_rddata, b_wb_dout, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [4:0]  b_rdaddr, b_wb_rdaddr;
  logic [2:0]  b_funct3;
  logic [7:0]  b_dm_wstrb;
  logic        b_ex_ready, b_stall, b_wb_valid, b_wb_memtoreg, b_wb_regwrite, b_exc_mis, b_exc_bus;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid, b_dm_err;

  mem_stage_hs #(.XLEN(32), .TIMEOUT(8), .CNT_W(4)) u32 (
    .clk(clk), .rst(rst), .ex_valid(a_ex_valid), .ex_ready(a_ex_ready),
    .ex_memread(a_memread), .ex_memwrite(a_memwrite), .ex_memtoreg(a_memtoreg),
    .ex_regwrite(a_regwrite), .ex_rdsrc(a_rdsrc), .ex_aluout(a_aluout),
    .ex_pctoreg(a_pctoreg), .ex_rs2data(a_rs2data), .ex_rdaddr(a_rdaddr),
    .ex_funct3(a_funct3), .fwd_rddata(a_fwd), .stall(a_stall), .wb_valid(a_wb_valid),
    .wb_rddata(a_wb_rddata), .wb_dout(a_wb_dout), .wb_rdaddr(a_wb_rdaddr),
    .wb_memtoreg(a_wb_memtoreg), .wb_regwrite(a_wb_regwrite), .exc_misalign(a_exc_mis),
    .exc_buserr(a_exc_bus), .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
    .dm_wstrb(a_dm_wstrb), .dm_wdata(a_dm_wdata), .dm_gnt(a_dm_gnt),
    .dm_rvalid(a_dm_rvalid), .dm_err(a_dm_err), .dm_rdata(a_dm_rdata)
  );

  mem_stage_hs #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .ex_valid(b_ex_valid), .ex_ready(b_ex_ready),
    .ex_memread(b_memread), .ex_memwrite(b_memwrite), .ex_memtoreg(b_memtoreg),
    .ex_regwrite(b_regwrite), .ex_rdsrc(b_rdsrc), .ex_aluout(b_aluout),
    .ex_pctoreg(b_pctoreg), .ex_rs2data(b_rs2data), .ex_rdaddr(b_rdaddr),
    .ex_funct3(b_funct3), .fwd_rddata(b_fwd), .stall(b_stall), .wb_valid(b_wb_valid),
    .wb_rddata(b_wb_rddata), .wb_dout(b_wb_dout), .wb_rdaddr(b_wb_rdaddr),
    .wb_memtoreg(b_wb_memtoreg), .wb_regwrite(b_wb_regwrite), .exc_misalign(b_exc_mis),
    .exc_buserr(b_exc_bus), .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
    .dm_wstrb(b_dm_wstrb), .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt),
    .dm_rvalid(b_dm_rvalid), .dm_err(b_dm_err), .dm_rdata(b_dm_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a 32-bit load, grant next cycle, respond the cycle after
  task automatic a_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    a_ex_valid = 1'b1; a_memread = 1'b1; a_memtoreg = 1'b1; a_regwrite = 1'b1;
    a_funct3 = f3; a_aluout = addr; a_rdaddr = 5'd7;
    step();
    a_ex_valid = 1'b0; a_memread = 1'b0; a_dm_gnt = 1'b1;
    step();
    a_dm_gnt = 1'b0; a_dm_rvalid = 1'b1; a_dm_rdata = rdata;
    step();
    a_dm_rvalid = 1'b0;
  endtask

  logic [31:0] alu_tab [4] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
  logic        src_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b0;
    {a_ex_valid, a_memread, a_memwrite, a_memtoreg, a_regwrite, a_rdsrc} = '0;
    {a_aluout, a_pctoreg, a_rs2data, a_dm_rdata} = '0;
    a_rdaddr = '0; a_funct3 = '0; {a_dm_gnt, a_dm_rvalid, a_dm_err} = '0;
    {b_ex_valid, b_memread, b_memwrite, b_memtoreg, b_regwrite, b_rdsrc} = '0;
    {b_aluout, b_pctoreg, b_rs2data, b_dm_rdata} = '0;
    b_rdaddr = '0; b_funct3 = '0; {b_dm_gnt, b_dm_rvalid, b_dm_err} = '0;
    step(); step();
    chk("rst_wb_valid", a_wb_valid, 0);
    chk("rst_dm_req", a_dm_req, 0);
    chk("rst_wstrb", a_dm_wstrb, 0);
    chk("rst_ex_ready", a_ex_ready, 1);
    chk("rst_stall", a_stall, 0);
    rst = 1'b1;
    step();

    // SB at 0x101, grant on second cycle, response two cycles later
    a_ex_valid = 1'b1; a_memwrite = 1'b1; a_funct3 = 3'b000;
    a_aluout = 32'h101; a_rs2data = 32'h1234_5678; a_regwrite = 1'b0;
    #1 chk("sb_ready_idle", a_ex_ready, 1);
    step();
    a_ex_valid = 1'b0; a_memwrite = 1'b0;
    chk("sb_req", a_dm_req, 1);
    chk("sb_we", a_dm_we, 1);
    chk("sb_wstrb", a_dm_wstrb, 4'b0010);
    chk("sb_wdata", a_dm_wdata, 32'h0000_7800);
    chk("sb_addr", a_dm_addr, 32'h100);
    chk("sb_ready_req", a_ex_ready, 0);
    step();
    chk("sb_req_hold", a_dm_req, 1);
    a_dm_gnt = 1'b1;
    step();
    a_dm_gnt = 1'b0;
    chk("sb_req_drop", a_dm_req, 0);
    chk("sb_ready_rsp", a_ex_ready, 0);
    step();
    chk("sb_no_wb_early", a_wb_valid, 0);
    a_dm_rvalid = 1'b1;
    step();
    a_dm_rvalid = 1'b0;
    chk("sb_wb_valid", a_wb_valid, 1);
    chk("sb_ready_back", a_ex_ready, 1);
    chk("sb_no_buserr", a_exc_bus, 0);
    step();
    chk("sb_single_pulse", a_wb_valid, 0);

    // Sub-word load extension
    a_load(3'b001, 32'h202, 32'h8001_ABCD);
    chk("lh_dout", a_wb_dout, 32'hFFFF_8001);
    chk("lh_regwrite", a_wb_regwrite, 1);
    chk("lh_rdaddr", a_wb_rdaddr, 7);
    a_load(3'b101, 32'h202, 32'h8001_ABCD);
    chk("lhu_dout", a_wb_dout, 32'h0000_8001);
    a_load(3'b000, 32'h203, 32'h8001_ABCD);
    chk("lb_dout", a_wb_dout, 32'hFFFF_FF80);
    a_load(3'b100, 32'h201, 32'h8001_ABCD);
    chk("lbu_dout", a_wb_dout, 32'h0000_00AB);

    // Misaligned and illegal accesses
    a_ex_valid = 1'b1; a_memread = 1'b1; a_regwrite = 1'b1;
    a_funct3 = 3'b010; a_aluout = 32'h206;
    step();
    chk("lw_mis_req", a_dm_req, 0);
    chk("lw_mis_valid", a_wb_valid, 1);
    chk("lw_mis_exc", a_exc_mis, 1);
    chk("lw_mis_regwrite", a_wb_regwrite, 0);
    chk("lw_mis_buserr", a_exc_bus, 0);
    a_funct3 = 3'b011; a_aluout = 32'h200;
    step();
    a_ex_valid = 1'b0; a_memread = 1'b0;
    chk("ill_req", a_dm_req, 0);
    chk("ill_buserr", a_exc_bus, 1);
    chk("ill_mis", a_exc_mis, 0);
    step();
    chk("exc_pulse_end", a_exc_bus, 0);

    // Timeout with grant held low
    a_ex_valid = 1'b1; a_memread = 1'b1; a_funct3 = 3'b010; a_aluout = 32'h100;
    step();
    a_ex_valid = 1'b0; a_memread = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_waiting", {a_wb_valid, a_dm_req}, 2'b01);
    end
    step();
    chk("to_buserr", a_exc_bus, 1);
    chk("to_valid", a_wb_valid, 1);
    chk("to_regwrite", a_wb_regwrite, 0);
    chk("to_req", a_dm_req, 0);
    chk("to_ready", a_ex_ready, 1);
    chk("to_stall", a_stall, 0);
    step();

    // Back-to-back ALU ops
    a_regwrite = 1'b1; a_pctoreg = 32'h0000_8004;
    for (int i = 0; i < 4; i++) begin
      a_ex_valid = 1'b1; a_aluout = alu_tab[i]; a_rdsrc = src_tab[i]; a_rdaddr = 5'(i + 1);
      #1;
      chk("alu_ready", a_ex_ready, 1);
      chk("alu_fwd", a_fwd, src_tab[i] ? 32'h0000_8004 : alu_tab[i]);
      step();
      chk("alu_wb_valid", a_wb_valid, 1);
      chk("alu_wb_rddata", a_wb_rddata, src_tab[i] ? 32'h0000_8004 : alu_tab[i]);
      chk("alu_wb_rdaddr", a_wb_rdaddr, i + 1);
    end
    a_ex_valid = 1'b0;
    step();
    chk("alu_idle", a_wb_valid, 0);

    // XLEN=64 LW at 0x0C
    b_ex_valid = 1'b1; b_memread = 1'b1; b_regwrite = 1'b1; b_funct3 = 3'b010; b_aluout = 64'h0C;
    step();
    b_ex_valid = 1'b0; b_memread = 1'b0;
    chk("b_lw_addr", b_dm_addr, 64'h08);
    b_dm_gnt = 1'b1;
    step();
    b_dm_gnt = 1'b0; b_dm_rvalid = 1'b1; b_dm_rdata = 64'h8000_0000_0000_0000;
    step();
    b_dm_rvalid = 1'b0;
    chk("b_lw_valid", b_wb_valid, 1);
    chk("b_lw_dout", b_wb_dout, 64'hFFFF_FFFF_8000_0000);

    // XLEN=64 SW at 0x0C
    b_ex_valid = 1'b1; b_memwrite = 1'b1; b_rs2data = 64'hAAAA_BBBB_1122_3344;
    step();
    b_ex_valid = 1'b0; b_memwrite = 1'b0;
    chk("b_sw_wstrb", b_dm_wstrb, 8'hF0);
    chk("b_sw_wdata", b_dm_wdata, 64'h1122_3344_0000_0000);
    b_dm_gnt = 1'b1;
    step();
    b_dm_gnt = 1'b0; b_dm_rvalid = 1'b1; b_dm_err = 1'b1;
    step();
    b_dm_rvalid = 1'b0; b_dm_err = 1'b0;
    chk("b_sw_err", b_exc_bus, 1);
    chk("b_sw_err_rw", b_wb_regwrite, 0);

    // Reset during RSP, then a stray response
    b_ex_valid = 1'b1; b_memread = 1'b1; b_funct3 = 3'b011; b_aluout = 64'h10;
    step();
    b_ex_valid = 1'b0; b_memread = 1'b0; b_dm_gnt = 1'b1;
    step();
    b_dm_gnt = 1'b0;
    chk("b_in_rsp", b_stall, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("b_rst_req", b_dm_req, 0);
    chk("b_rst_wb_valid", b_wb_valid, 0);
    chk("b_rst_dout", b_wb_dout, 0);
    chk("b_rst_rddata", b_wb_rddata, 0);
    chk("b_rst_addr", b_dm_addr, 0);
    chk("b_rst_stall", b_stall, 0);
    chk("b_rst_ready", b_ex_ready, 1);
    b_dm_rvalid = 1'b1; b_dm_rdata = 64'h1234;
    step();
    b_dm_rvalid = 1'b0;
    chk("b_late_rvalid", b_wb_valid, 0);
    step();
    chk("b_late_rvalid2", b_wb_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
